prf_multiport: RTL and testbench

Parametrised physical register file for the out-of-order core. It holds PRF_SIZE physical registers, each with a per-entry ready bit. Reads are asynchronous over NUM_RD ports feeding the reservation-station issue paths (ALU simple/mul/mem operand pairs). Writes are clocked over NUM_WR CDB ports, and dispatch-time allocation clears ready bits. Physical register 0 is the hardwired zero register.

---
 rtl/prf_multiport.sv | 79 +++++++
 tb/tb_prf_multiport.sv | 197 +++++++++++++++++++
 2 files changed

// File: rtl/prf_multiport.sv
// Physical register file: asynchronous multi-port reads, CDB writes, dispatch-time ready clear.
// Optional same-cycle write-to-read forwarding is enabled by defining PRF_BYPASS_EN.
module prf_multiport #(
  parameter int PRF_SIZE  = 64,
  parameter int IDX_W     = 6,
  parameter int DATA_W    = 64,
  parameter int NUM_RD    = 6,
  parameter int NUM_WR    = 3,
  parameter int NUM_ALLOC = 2
) (
  input  logic                        clock,
  input  logic                        reset,
  input  logic [NUM_RD*IDX_W-1:0]     rd_idx,
  output logic [NUM_RD*DATA_W-1:0]    rd_value,
  output logic [NUM_RD-1:0]           rd_ready,
  input  logic [NUM_WR-1:0]           wr_en,
  input  logic [NUM_WR*IDX_W-1:0]     wr_idx,
  input  logic [NUM_WR*DATA_W-1:0]    wr_value,
  input  logic [NUM_ALLOC-1:0]        alloc_en,
  input  logic [NUM_ALLOC*IDX_W-1:0]  alloc_idx
);

  logic [DATA_W-1:0]   value_q [PRF_SIZE];
  logic [PRF_SIZE-1:0] ready_q;

  // Later assignments win: higher write ports override lower ones, and allocs
  // come after writes so a coinciding alloc leaves the entry not ready.
  always_ff @(posedge clock) begin
    if (reset) begin
      for (int r = 0; r < PRF_SIZE; r++) begin
        value_q[r] <= '0;
      end
      ready_q <= '1;
    end else begin
      for (int k = 0; k < NUM_WR; k++) begin
        if (wr_en[k] && (wr_idx[k*IDX_W +: IDX_W] != '0)) begin
          value_q[wr_idx[k*IDX_W +: IDX_W]] <= wr_value[k*DATA_W +: DATA_W];
          ready_q[wr_idx[k*IDX_W +: IDX_W]] <= 1'b1;
        end
      end
      for (int j = 0; j < NUM_ALLOC; j++) begin
        if (alloc_en[j] && (alloc_idx[j*IDX_W +: IDX_W] != '0)) begin
          ready_q[alloc_idx[j*IDX_W +: IDX_W]] <= 1'b0;
        end
      end
    end
  end

  for (genvar i = 0; i < NUM_RD; i++) begin : g_rd
    logic [IDX_W-1:0]  idx;
    logic [DATA_W-1:0] val;
    logic              rdy;

    assign idx = rd_idx[i*IDX_W +: IDX_W];

    // Register 0 is forced last so neither stored state nor forwarding can leak through it.
    always_comb begin
      val = value_q[idx];
      rdy = ready_q[idx];
`ifdef PRF_BYPASS_EN
      for (int k = 0; k < NUM_WR; k++) begin
        if (wr_en[k] && (wr_idx[k*IDX_W +: IDX_W] == idx)) begin
          val = wr_value[k*DATA_W +: DATA_W];
          rdy = 1'b1;
        end
      end
`else
`endif
      if (idx == '0) begin
        val = '0;
        rdy = 1'b1;
      end
    end

    assign rd_value[i*DATA_W +: DATA_W] = val;
    assign rd_ready[i] = rdy;
  end

endmodule

// File: tb/tb_prf_multiport.sv
// Bench for prf_multiport: expected reads are queued as stimulus is driven and
// compared against the read ports once the combinational outputs settle.
module tb_prf_multiport;

  localparam int PRF_SIZE  = 64;
  localparam int IDX_W     = 6;
  localparam int DATA_W    = 64;
  localparam int NUM_RD    = 6;
  localparam int NUM_WR    = 3;
  localparam int NUM_ALLOC = 2;

  logic                       clock;
  logic                       reset;
  logic [NUM_RD*IDX_W-1:0]    rd_idx;
  logic [NUM_RD*DATA_W-1:0]   rd_value;
  logic [NUM_RD-1:0]          rd_ready;
  logic [NUM_WR-1:0]          wr_en;
  logic [NUM_WR*IDX_W-1:0]    wr_idx;
  logic [NUM_WR*DATA_W-1:0]   wr_value;
  logic [NUM_ALLOC-1:0]       alloc_en;
  logic [NUM_ALLOC*IDX_W-1:0] alloc_idx;

  typedef struct {
    string       tag;
    int          port;
    logic [63:0] val;
    logic        rdy;
  } exp_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_fail   = 0;
  bit   bypass   = 1'b0;

  prf_multiport #(
    .PRF_SIZE(PRF_SIZE), .IDX_W(IDX_W), .DATA_W(DATA_W),
    .NUM_RD(NUM_RD), .NUM_WR(NUM_WR), .NUM_ALLOC(NUM_ALLOC)
  ) dut (
    .clock(clock), .reset(reset),
    .rd_idx(rd_idx), .rd_value(rd_value), .rd_ready(rd_ready),
    .wr_en(wr_en), .wr_idx(wr_idx), .wr_value(wr_value),
    .alloc_en(alloc_en), .alloc_idx(alloc_idx)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    n_checks++;
    if (observed !== expected) begin
      n_fail++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic clearStrobes();
    wr_en    = '0;
    alloc_en = '0;
  endtask

  task automatic setRead(input int port, input int idx);
    rd_idx[port*IDX_W +: IDX_W] = IDX_W'(idx);
  endtask

  task automatic applyStimulus(input int port, input int idx, input string tag,
                               input logic [63:0] val, input logic rdy);
    exp_t e;
    setRead(port, idx);
    e.tag = tag; e.port = port; e.val = val; e.rdy = rdy;
    sb.push_back(e);
  endtask

  task automatic setWrite(input int port, input int idx, input logic [63:0] val);
    wr_en[port] = 1'b1;
    wr_idx[port*IDX_W +: IDX_W] = IDX_W'(idx);
    wr_value[port*DATA_W +: DATA_W] = val;
  endtask

  task automatic setAlloc(input int port, input int idx);
    alloc_en[port] = 1'b1;
    alloc_idx[port*IDX_W +: IDX_W] = IDX_W'(idx);
  endtask

  task automatic drainScoreboard();
    exp_t e;
    #1;
    while (sb.size() > 0) begin
      e = sb.pop_front();
      checkOutput({e.tag, "_value"}, rd_value[e.port*DATA_W +: DATA_W], e.val);
      checkOutput({e.tag, "_ready"}, 64'(rd_ready[e.port]), 64'(e.rdy));
    end
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
`ifdef PRF_BYPASS_EN
    bypass = 1'b1;
`endif
    reset = 1'b1; rd_idx = '0; wr_en = '0; wr_idx = '0; wr_value = '0;
    alloc_en = '0; alloc_idx = '0;
    step();
    step();
    reset = 1'b0;

    // Reset state on every port
    for (int p = 0; p < NUM_RD; p++) begin
      int idxs [3] = '{0, 1, 63};
      applyStimulus(p, idxs[p % 3], $sformatf("reset_p%0d", p), 64'h0, 1'b1);
    end
    drainScoreboard();

    // Alloc then write idx 5
    setAlloc(0, 5); step(); clearStrobes();
    applyStimulus(0, 5, "alloc5", 64'h0, 1'b0);
    drainScoreboard();
    setWrite(0, 5, 64'hDEADBEEF); step(); clearStrobes();
    applyStimulus(0, 5, "write5", 64'hDEADBEEF, 1'b1);
    drainScoreboard();

    // Same-cycle read of a CDB write to allocated idx 7
    setAlloc(1, 7); step(); clearStrobes();
    setWrite(1, 7, 64'h1234);
    if (bypass) applyStimulus(3, 7, "byp7_T", 64'h1234, 1'b1);
    else        applyStimulus(3, 7, "byp7_T", 64'h0, 1'b0);
    drainScoreboard();
    step(); clearStrobes();
    applyStimulus(3, 7, "byp7_T1", 64'h1234, 1'b1);
    drainScoreboard();

    // Write-write collision: highest port wins
    setWrite(0, 9, 64'hAA); setWrite(2, 9, 64'hBB);
    if (bypass) applyStimulus(4, 9, "coll9_T", 64'hBB, 1'b1);
    else        applyStimulus(4, 9, "coll9_T", 64'h0, 1'b1);
    drainScoreboard();
    step(); clearStrobes();
    applyStimulus(4, 9, "coll9", 64'hBB, 1'b1);
    drainScoreboard();

    // Write plus alloc on idx 10: value lands, ready ends low
    setWrite(1, 10, 64'h77); setAlloc(1, 10);
    if (bypass) applyStimulus(2, 10, "wa10_T", 64'h77, 1'b1);
    else        applyStimulus(2, 10, "wa10_T", 64'h0, 1'b1);
    drainScoreboard();
    step(); clearStrobes();
    applyStimulus(2, 10, "wa10", 64'h77, 1'b0);
    drainScoreboard();

    // Double alloc of idx 11
    setAlloc(0, 11); setAlloc(1, 11); step(); clearStrobes();
    applyStimulus(5, 11, "dalloc11", 64'h0, 1'b0);
    drainScoreboard();

    // Zero register ignores write and alloc, before and after the edge
    setWrite(0, 0, 64'hFF); setAlloc(0, 0);
    for (int p = 0; p < NUM_RD; p++) applyStimulus(p, 0, $sformatf("zero_T_p%0d", p), 64'h0, 1'b1);
    drainScoreboard();
    step(); clearStrobes();
    for (int p = 0; p < NUM_RD; p++) applyStimulus(p, 0, $sformatf("zero_p%0d", p), 64'h0, 1'b1);
    drainScoreboard();

    // Parallel distinct writes, then every port reads a different entry
    setWrite(0, 20, 64'h1111_0000_0000_0020);
    setWrite(1, 21, 64'h2222_0000_0000_0021);
    setWrite(2, 22, 64'h3333_0000_0000_0022);
    step(); clearStrobes();
    applyStimulus(0, 22, "par_p0", 64'h3333_0000_0000_0022, 1'b1);
    applyStimulus(1, 21, "par_p1", 64'h2222_0000_0000_0021, 1'b1);
    applyStimulus(2, 20, "par_p2", 64'h1111_0000_0000_0020, 1'b1);
    applyStimulus(3, 5,  "par_p3", 64'hDEADBEEF, 1'b1);
    applyStimulus(4, 10, "par_p4", 64'h77, 1'b0);
    applyStimulus(5, 63, "par_p5", 64'h0, 1'b1);
    drainScoreboard();

    // Reset wins over a coinciding write and clears earlier state
    setWrite(0, 12, 64'h55); setAlloc(0, 13); reset = 1'b1;
    step(); clearStrobes(); reset = 1'b0;
    applyStimulus(0, 12, "rst12", 64'h0, 1'b1);
    applyStimulus(1, 5,  "rst5", 64'h0, 1'b1);
    applyStimulus(2, 10, "rst10", 64'h0, 1'b1);
    applyStimulus(3, 13, "rst13", 64'h0, 1'b1);
    drainScoreboard();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
